// File: rtl/l15_msg_arbiter_pkg.sv
// Shared widths, the empty message type and the output slot state encoding
// for the L1.5 -> L2 message arbiter.
package l15_msg_arbiter_pkg;

    localparam int unsigned MSG_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned TAG_WIDTH  = 8;
    localparam int unsigned OWNER_BITS = 4;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY = '0;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

endpackage

// File: rtl/l15_msg_arbiter_rr_pick.sv
// Round-robin priority picker: returns the first set request at or after
// ptr, wrapping modulo N (N must be a power of two).
module rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any
);

    logic [W-1:0] idx;

    // Scan from ptr upward; W-bit addition provides the modulo-N wrap.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + W'(k);
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l15_msg_arbiter.sv
// Registered valid/ready arbiter sharing one L2-bound message channel among
// NUM_REQ L1.5 requesters and one memory-response source. Memory wins unless
// it has already taken MAX_MEM_BURST grants in a row while a core waits.
module l15_msg_arbiter
    import l15_msg_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned MSG_W         = MSG_WIDTH,
    parameter int unsigned DATA_W        = DATA_WIDTH,
    parameter int unsigned TAG_W         = TAG_WIDTH,
    parameter int unsigned SRC_W         = OWNER_BITS,
    parameter int unsigned MAX_MEM_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MSG_W-1:0]  req_type,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      mem_valid,
    input  logic [MSG_W-1:0]          mem_type,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic [TAG_W-1:0]          mem_tag,
    output logic                      mem_ready,
    output logic                      out_valid,
    output logic [MSG_W-1:0]          out_type,
    output logic [DATA_W-1:0]         out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic [SRC_W-1:0]          out_source,
    output logic                      out_from_mem,
    input  logic                      out_ready
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned STK_W = $clog2(MAX_MEM_BURST + 1);
    localparam logic [STK_W-1:0] MAX_STK = STK_W'(MAX_MEM_BURST);

    slot_state_t      state;
    logic [PTR_W-1:0] rr_ptr;
    logic [STK_W-1:0] mem_streak;

    logic [PTR_W-1:0] core_idx;
    logic             core_any;
    logic             any_core;
    logic             mem_pick;
    logic             accept_en;
    logic             core_grant;
    logic             mem_grant;
    logic [MSG_W-1:0]  sel_type;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic [SRC_W-1:0]  sel_source;

    rr_pick #(.N(NUM_REQ), .W(PTR_W)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (core_idx),
        .any   (core_any)
    );

    // Grant decision; rst masks every ready so nothing is accepted in reset.
    always_comb begin
        any_core   = |req_valid;
        mem_pick   = mem_valid & (!any_core | (mem_streak < MAX_STK));
        accept_en  = (state == SLOT_EMPTY) | (out_ready & out_valid);
        mem_grant  = !rst & accept_en & mem_pick;
        core_grant = !rst & accept_en & !mem_pick & core_any;
        mem_ready  = mem_grant;
        req_ready  = '0;
        if (core_grant) req_ready[core_idx] = 1'b1;
    end

    // Payload of whichever source wins this cycle.
    always_comb begin
        if (mem_pick) begin
            sel_type   = mem_type;
            sel_data   = mem_data;
            sel_tag    = mem_tag;
            sel_source = '0;
        end else begin
            sel_type   = req_type[core_idx*MSG_W +: MSG_W];
            sel_data   = req_data[core_idx*DATA_W +: DATA_W];
            sel_tag    = req_tag[core_idx*TAG_W +: TAG_W];
            sel_source = SRC_W'(core_idx);
        end
    end

    // Output slot FSM: load on grant, drain on out_ready, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SLOT_EMPTY;
            out_valid    <= 1'b0;
            out_type     <= MSG_TYPE_EMPTY;
            out_data     <= '0;
            out_tag      <= '0;
            out_source   <= '0;
            out_from_mem <= 1'b0;
        end else if (mem_grant || core_grant) begin
            state        <= SLOT_FULL;
            out_valid    <= 1'b1;
            out_type     <= sel_type;
            out_data     <= sel_data;
            out_tag      <= sel_tag;
            out_source   <= sel_source;
            out_from_mem <= mem_grant;
        end else if (state == SLOT_FULL && out_ready) begin
            state        <= SLOT_EMPTY;
            out_valid    <= 1'b0;
            out_type     <= MSG_TYPE_EMPTY;
            out_data     <= '0;
            out_tag      <= '0;
            out_source   <= '0;
            out_from_mem <= 1'b0;
        end
    end

    // Fairness state: round-robin pointer and bounded memory streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            mem_streak <= '0;
        end else begin
            if (core_grant) rr_ptr <= core_idx + 1'b1;
            if (!any_core || core_grant)
                mem_streak <= '0;
            else if (mem_grant && mem_streak != MAX_STK)
                mem_streak <= mem_streak + 1'b1;
        end
    end

endmodule

// File: tb/tb_l15_msg_arbiter.sv
// Directed, table-driven bench for l15_msg_arbiter with NUM_REQ=2.
module tb_l15_msg_arbiter;
    import l15_msg_arbiter_pkg::*;

    localparam int unsigned N = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N-1:0]               req_valid;
    logic [N*MSG_WIDTH-1:0]     req_type;
    logic [N*DATA_WIDTH-1:0]    req_data;
    logic [N*TAG_WIDTH-1:0]     req_tag;
    logic [N-1:0]               req_ready;
    logic                       mem_valid;
    logic [MSG_WIDTH-1:0]       mem_type;
    logic [DATA_WIDTH-1:0]      mem_data;
    logic [TAG_WIDTH-1:0]       mem_tag;
    logic                       mem_ready;
    logic                       out_valid;
    logic [MSG_WIDTH-1:0]       out_type;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [TAG_WIDTH-1:0]       out_tag;
    logic [OWNER_BITS-1:0]      out_source;
    logic                       out_from_mem;
    logic                       out_ready;

    logic [MSG_WIDTH-1:0]  core_type [N];
    logic [DATA_WIDTH-1:0] core_data [N];
    logic [TAG_WIDTH-1:0]  core_tag  [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign req_type = {core_type[1], core_type[0]};
    assign req_data = {core_data[1], core_data[0]};
    assign req_tag  = {core_tag[1],  core_tag[0]};

    l15_msg_arbiter #(
        .NUM_REQ       (N),
        .MSG_W         (MSG_WIDTH),
        .DATA_W        (DATA_WIDTH),
        .TAG_W         (TAG_WIDTH),
        .SRC_W         (OWNER_BITS),
        .MAX_MEM_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_type     (req_type),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .mem_valid    (mem_valid),
        .mem_type     (mem_type),
        .mem_data     (mem_data),
        .mem_tag      (mem_tag),
        .mem_ready    (mem_ready),
        .out_valid    (out_valid),
        .out_type     (out_type),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_source   (out_source),
        .out_from_mem (out_from_mem),
        .out_ready    (out_ready)
    );

    typedef struct {
        logic [1:0] rv;
        logic       mv;
        logic       ordy;
        logic [1:0] exp_rr;
        logic       exp_mr;
        logic       exp_ov;
        logic [3:0] exp_src;
        logic       exp_fm;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // One cycle: drive at negedge, check readies, check registered outputs after posedge.
    task automatic step(input string nm, input logic [1:0] rv, input logic mv,
                        input logic ordy, input logic r, input logic [1:0] err,
                        input logic emr, input logic eov, input logic [3:0] esrc,
                        input logic efm);
        @(negedge clk);
        req_valid = rv;
        mem_valid = mv;
        out_ready = ordy;
        rst       = r;
        #1;
        check({nm, " req_ready"}, req_ready, err);
        check({nm, " mem_ready"}, mem_ready, emr);
        @(posedge clk);
        #1;
        check({nm, " out_valid"}, out_valid, eov);
        if (eov) begin
            check({nm, " out_from_mem"}, out_from_mem, efm);
            check({nm, " out_source"}, out_source, efm ? 4'd0 : esrc);
            check({nm, " out_type"}, out_type, efm ? mem_type : core_type[esrc[0]]);
            check({nm, " out_tag"},  out_tag,  efm ? mem_tag  : core_tag[esrc[0]]);
            check({nm, " out_data"}, out_data, efm ? mem_data : core_data[esrc[0]]);
        end else begin
            check({nm, " out_type empty"}, out_type, MSG_TYPE_EMPTY);
        end
    endtask

    initial begin
        core_type[0] = 8'h03; core_data[0] = 64'h1000; core_tag[0] = 8'h10;
        core_type[1] = 8'h05; core_data[1] = 64'h1111; core_tag[1] = 8'h11;
        mem_type  = MSG_TYPE_EMPTY;  // empty type on a valid message must pass through
        mem_data  = 64'hDEAD_BEEF;
        mem_tag   = 8'hEE;

        // Reset with every source valid: no ready may be raised.
        rst = 1'b1; req_valid = 2'b11; mem_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst req_ready", req_ready, 2'b00);
        check("rst mem_ready", mem_ready, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_type", out_type, MSG_TYPE_EMPTY);
        check("rst out_tag", out_tag, 8'h00);
        check("rst out_data", out_data, 64'h0);
        check("rst out_source", out_source, 4'd0);
        check("rst out_from_mem", out_from_mem, 1'b0);
        check("rst rr_ptr", dut.rr_ptr, 1'b0);
        @(posedge clk);

        // Idle after reset, 5 cycles
        for (int i = 0; i < 5; i++) tbl.push_back('{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0});
        // Two cores alternate
        tbl.push_back('{2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 4'd0, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 4'd0, 1'b0});
        tbl.push_back('{2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0});
        // Memory burst of 4, then core 1, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) tbl.push_back('{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1});
            tbl.push_back('{2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0});
        end
        // Core 1 sole requester with rr_ptr=0, then drain
        tbl.push_back('{2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0});
        // Streak clears on a cycle with no core valid
        tbl.push_back('{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1});
        tbl.push_back('{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1});
        for (int i = 0; i < 4; i++) tbl.push_back('{2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1});
        tbl.push_back('{2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0});
        tbl.push_back('{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0});

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].rv, tbl[i].mv, tbl[i].ordy, 1'b0,
                 tbl[i].exp_rr, tbl[i].exp_mr, tbl[i].exp_ov, tbl[i].exp_src, tbl[i].exp_fm);
        check("table rr_ptr", dut.rr_ptr, 1'b0);

        // Backpressure: slot holds core 0 message while core 1 waits
        core_tag[0] = 8'h05; core_data[0] = 64'hA;
        step("bp load", 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            step($sformatf("bp hold%0d", i), 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0);
        check("bp held tag", out_tag, 8'h05);
        step("bp release", 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0);
        step("bp drain", 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset mid-transfer with core 1 pending
        step("mr load", 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'd0, 1'b0);
        check("mr rr_ptr before", dut.rr_ptr, 1'b1);
        step("mr rst", 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        check("mr rr_ptr after", dut.rr_ptr, 1'b0);
        step("mr regrant", 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'd1, 1'b0);
        step("mr drain", 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
